// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one RAM port between two masters that each speak the MFA/MFC
//   four-phase handshake. M0 is the control unit's MAR/MBR port, M1 is the
//   DMA / program-loader port. Requests are arbitrated round-robin. The
//   granted master's address, control and write data are registered onto
//   the RAM side. Read data is latched per master. A watchdog aborts any
//   RAM access that never completes.
//
// Ports
//   Clk, Reset             clock (posedge), asynchronous active-high reset
//   M0_* / M1_*            master handshake: MFA, RW, WB, ADDR, WDATA in;
//                          RDATA, MFC out
//   RAM_MFA/RW/WB/ADDR/WDATA  registered request to the RAM
//   RAM_RDATA, RAM_MFC     RAM read data and completion
//   GRANT                  one-hot current owner, 00 when idle
//   TIMEOUT                one-cycle pulse when the watchdog aborts an access
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              M0_MFA,
  input  logic              M0_RW,
  input  logic              M0_WB,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic              M0_MFC,
  input  logic              M1_MFA,
  input  logic              M1_RW,
  input  logic              M1_WB,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic              M1_MFC,
  output logic              RAM_MFA,
  output logic              RAM_RW,
  output logic              RAM_WB,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  input  logic              RAM_MFC,
  output logic [1:0]        GRANT,
  output logic              TIMEOUT
);

  localparam int WD_W = $clog2(TO_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_m1, last_m1_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic [1:0]        grant_nxt;
  logic              ram_mfa_nxt, ram_rw_nxt, ram_wb_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_wdata_nxt;
  logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic              m0_mfc_nxt, m1_mfc_nxt;
  logic              timeout_nxt;
  logic              pick_m1;
  logic              owner_mfa;

  // State and every output are registered; reset clears them immediately
  // so an in-flight access is dropped without waiting for a clock edge.
  // last_m1 resets to 1 so that M0 wins the first tie.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      last_m1   <= 1'b1;
      wd_cnt    <= '0;
      GRANT     <= 2'b00;
      RAM_MFA   <= 1'b0;
      RAM_RW    <= 1'b0;
      RAM_WB    <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_WDATA <= '0;
      M0_RDATA  <= '0;
      M1_RDATA  <= '0;
      M0_MFC    <= 1'b0;
      M1_MFC    <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_m1   <= last_m1_nxt;
      wd_cnt    <= wd_cnt_nxt;
      GRANT     <= grant_nxt;
      RAM_MFA   <= ram_mfa_nxt;
      RAM_RW    <= ram_rw_nxt;
      RAM_WB    <= ram_wb_nxt;
      RAM_ADDR  <= ram_addr_nxt;
      RAM_WDATA <= ram_wdata_nxt;
      M0_RDATA  <= m0_rdata_nxt;
      M1_RDATA  <= m1_rdata_nxt;
      M0_MFC    <= m0_mfc_nxt;
      M1_MFC    <= m1_mfc_nxt;
      TIMEOUT   <= timeout_nxt;
    end
  end

  // Next-state and next-output logic. Everything holds by default except
  // TIMEOUT, which is a single-cycle pulse.
  always_comb begin
    state_nxt     = state;
    last_m1_nxt   = last_m1;
    wd_cnt_nxt    = wd_cnt;
    grant_nxt     = GRANT;
    ram_mfa_nxt   = RAM_MFA;
    ram_rw_nxt    = RAM_RW;
    ram_wb_nxt    = RAM_WB;
    ram_addr_nxt  = RAM_ADDR;
    ram_wdata_nxt = RAM_WDATA;
    m0_rdata_nxt  = M0_RDATA;
    m1_rdata_nxt  = M1_RDATA;
    m0_mfc_nxt    = M0_MFC;
    m1_mfc_nxt    = M1_MFC;
    timeout_nxt   = 1'b0;
    pick_m1       = M1_MFA && (!M0_MFA || !last_m1);
    owner_mfa     = GRANT[1] ? M1_MFA : M0_MFA;

    case (state)
      IDLE: begin
        // A stale RAM_MFC left over from a previous access would complete
        // the next one instantly, so no grant is issued while it is high.
        if (!RAM_MFC && (M0_MFA || M1_MFA)) begin
          grant_nxt     = pick_m1 ? 2'b10 : 2'b01;
          ram_mfa_nxt   = 1'b1;
          ram_rw_nxt    = pick_m1 ? M1_RW    : M0_RW;
          ram_wb_nxt    = pick_m1 ? M1_WB    : M0_WB;
          ram_addr_nxt  = pick_m1 ? M1_ADDR  : M0_ADDR;
          ram_wdata_nxt = pick_m1 ? M1_WDATA : M0_WDATA;
          wd_cnt_nxt    = '0;
          state_nxt     = ISSUE;
        end
      end

      ISSUE: begin
        if (RAM_MFC) begin
          ram_mfa_nxt = 1'b0;
          if (GRANT[0]) begin
            m0_mfc_nxt = 1'b1;
            if (RAM_RW) m0_rdata_nxt = RAM_RDATA;
          end
          if (GRANT[1]) begin
            m1_mfc_nxt = 1'b1;
            if (RAM_RW) m1_rdata_nxt = RAM_RDATA;
          end
          state_nxt = ACK;
        end else if (wd_cnt == WD_LAST) begin
          // Abort: the master still gets its completion so it never hangs,
          // and a read returns all-ones as a recognisable poison value.
          ram_mfa_nxt = 1'b0;
          timeout_nxt = 1'b1;
          if (GRANT[0]) begin
            m0_mfc_nxt = 1'b1;
            if (RAM_RW) m0_rdata_nxt = '1;
          end
          if (GRANT[1]) begin
            m1_mfc_nxt = 1'b1;
            if (RAM_RW) m1_rdata_nxt = '1;
          end
          state_nxt = ACK;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end

      ACK: begin
        // Both the master and the RAM must have released their side before
        // the port is reused, otherwise a lingering RAM_MFC would leak into
        // the next access.
        if (!owner_mfa && !RAM_MFC) begin
          m0_mfc_nxt  = 1'b0;
          m1_mfc_nxt  = 1'b0;
          grant_nxt   = 2'b00;
          last_m1_nxt = GRANT[1];
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
